// File: rtl/keypad_pkg.sv
// rtl/keypad_pkg.sv - key codes, press-FSM states and a clog2 helper for the keypad front end
package keypad_pkg;

  localparam logic [1:0] KEY_B0 = 2'd0;
  localparam logic [1:0] KEY_B1 = 2'd1;
  localparam logic [1:0] KEY_B2 = 2'd2;
  localparam logic [1:0] KEY_B3 = 2'd3;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    FIRE     = 2'd1,
    WAIT_REL = 2'd2
  } press_state_e;

  // Bits needed to hold the values 0 .. value-1; returns 0 for value <= 1.
  function automatic int clog2(input longint unsigned value);
    int result;
    result = 0;
    for (int i = 0; i < 64; i++) begin
      if ((64'd1 << i) < value) result = i + 1;
    end
    return result;
  endfunction

endpackage

// File: rtl/keypad_code_tx_if.sv
// rtl/keypad_code_tx_if.sv - key strobe and inactivity signals shared with the password FSM
interface keypad_code_tx_if;
  logic       S_INATI;
  logic [1:0] COD;
  logic       EN;
  logic       TEMP_INATI;

  modport master (output COD, output EN, output TEMP_INATI, input S_INATI);
  modport slave  (input COD, input EN, input TEMP_INATI, output S_INATI);
endinterface

// File: rtl/btn_debounce.sv
// rtl/btn_debounce.sv - one-button 2-FF synchronizer, polarity normaliser and debouncer
module btn_debounce
  import keypad_pkg::*;
#(
  parameter int DEB_CYCLES = 500000,
  parameter bit ACTIVE_LOW = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_raw,
  output logic pressed
);

  localparam int  CW_RAW  = clog2(64'(DEB_CYCLES));
  localparam int  CW      = (CW_RAW < 1) ? 1 : CW_RAW;
  localparam logic REL_RAW = ACTIVE_LOW;

  logic          sync1_q, sync1_d;
  logic          sync2_q, sync2_d;
  logic          deb_q, deb_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          lvl;

  always_comb begin
    sync1_d = btn_raw;
    sync2_d = sync1_q;
    lvl     = sync2_q ^ ACTIVE_LOW;
    deb_d   = deb_q;
    cnt_d   = '0;
    // Count only while the synchronized level disagrees; any agreement restarts it.
    if (lvl != deb_q) begin
      if (cnt_q == CW'(DEB_CYCLES - 1)) begin
        deb_d = lvl;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync1_q <= REL_RAW;
      sync2_q <= REL_RAW;
      deb_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      deb_q   <= deb_d;
      cnt_q   <= cnt_d;
    end
  end

  assign pressed = deb_q;

endmodule

// File: rtl/keypad_code_tx.sv
// rtl/keypad_code_tx.sv - debounced keypad to COD/EN strobes plus inactivity timeout
module keypad_code_tx
  import keypad_pkg::*;
#(
  parameter int DEB_CYCLES     = 500000,
  parameter int TIMEOUT_CYCLES = 250000000,
  parameter bit BTN_ACTIVE_LOW = 1'b1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [3:0]         BTN,
  keypad_code_tx_if.master   kif
);

  localparam int TW_RAW = clog2(64'(TIMEOUT_CYCLES));
  localparam int TW     = (TW_RAW < 1) ? 1 : TW_RAW;

  logic [3:0] deb;

  for (genvar i = 0; i < 4; i++) begin : g_btn
    btn_debounce #(
      .DEB_CYCLES (DEB_CYCLES),
      .ACTIVE_LOW (BTN_ACTIVE_LOW)
    ) u_deb (
      .clk     (clk),
      .rst_n   (rst_n),
      .btn_raw (BTN[i]),
      .pressed (deb[i])
    );
  end

  logic [2:0] n_pressed;
  logic [1:0] key_idx;

  always_comb begin
    n_pressed = '0;
    key_idx   = KEY_B0;
    for (int i = 0; i < 4; i++) begin
      if (deb[i]) begin
        n_pressed = n_pressed + 3'd1;
        key_idx   = 2'(i);
      end
    end
  end

  press_state_e state_q, state_d;
  logic [1:0]   cod_q, cod_d;
  logic         en;

  // COD is loaded on entry to FIRE so it is already valid while EN is high.
  always_comb begin
    state_d = state_q;
    cod_d   = cod_q;
    unique case (state_q)
      IDLE: begin
        if (n_pressed == 3'd1) begin
          state_d = FIRE;
          cod_d   = key_idx;
        end else if (n_pressed > 3'd1) begin
          state_d = WAIT_REL;
        end
      end
      FIRE:     state_d = WAIT_REL;
      WAIT_REL: if (n_pressed == 3'd0) state_d = IDLE;
      default:  state_d = IDLE;
    endcase
  end

  assign en = (state_q == FIRE);

  logic [TW-1:0] cnt_q, cnt_d;
  logic          temp_q, temp_d;

  // A fresh key press restarts the inactivity window even at the limit.
  always_comb begin
    cnt_d  = cnt_q;
    temp_d = temp_q;
    if (!kif.S_INATI || en) begin
      cnt_d  = '0;
      temp_d = 1'b0;
    end else if (cnt_q == TW'(TIMEOUT_CYCLES - 1)) begin
      temp_d = 1'b1;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cod_q   <= KEY_B0;
      cnt_q   <= '0;
      temp_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cod_q   <= cod_d;
      cnt_q   <= cnt_d;
      temp_q  <= temp_d;
    end
  end

  assign kif.COD        = cod_q;
  assign kif.EN         = en;
  assign kif.TEMP_INATI = temp_q;

endmodule
